bp_uart_bridge: RTL and testbench

Host-side link stage directly upstream of the correlator's BytePipe register interface. Converts an asynchronous 8N1 UART line into a BytePipe byte stream that feeds the correlator's incoming port. Serializes the correlator's outgoing BytePipe bytes back onto the UART TX line. Received bytes are buffered in a small FIFO so host bursts survive short ready stalls.

---
 rtl/bp_uart_bridge_pkg.sv | 34 +++
 rtl/bp_uart_bridge_rxfifo.sv | 64 ++++++
 rtl/bp_uart_bridge.sv | 165 ++++++++++++++++
 tb/tb_bp_uart_bridge.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_uart_bridge_pkg.sv
// ============================================================================
//  Module   : bpUartPkg
//  Brief    : Shared state encodings, frame constants and counter sizing.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package bpUartPkg;

   localparam int UART_DATA_W     = 8;
   localparam int UART_FRAME_BITS = 10;

   typedef enum logic [2:0] {
      RX_IDLE  = 3'd0,
      RX_START = 3'd1,
      RX_DATA  = 3'd2,
      RX_STOP  = 3'd3,
      RX_BREAK = 3'd4
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   function automatic int bit_cnt_width(input int clks_per_bit);
      return $clog2(clks_per_bit);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bp_uart_bridge_rxfifo.sv
// ============================================================================
//  Module   : bp_uart_rxfifo
//  Brief    : Synchronous byte FIFO with wrap-bit pointers and registered read data.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bp_uart_rxfifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_cg,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic             o_full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_data;
   logic             w_push_ok;
   logic             w_pop_ok;
   logic [AW:0]      w_rd_next;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop_ok  = i_cg & i_pop & ~o_empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
   assign w_push_ok = i_cg & i_push & (~o_full | w_pop_ok);
   assign w_rd_next = r_rd_ptr + {{AW{1'b0}}, w_pop_ok};
   assign o_data    = r_data;

   always_ff @(posedge i_clk) begin
      if (w_push_ok)
         r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_data   <= '0;
      end else if (i_cg) begin
         if (w_push_ok)
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         r_rd_ptr <= w_rd_next;
         // The head slot is being written this cycle: forward the incoming byte.
         if (w_push_ok && (r_wr_ptr == w_rd_next))
            r_data <= i_data;
         else
            r_data <= r_mem[w_rd_next[AW-1:0]];
      end
   end

endmodule

`default_nettype wire

// File: rtl/bp_uart_bridge.sv
// ============================================================================
//  Module   : bp_uart_bridge
//  Brief    : 8N1 UART to BytePipe bridge with buffered RX and idle-ready TX.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bp_uart_bridge
   import bpUartPkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int RXFIFO_DEPTH = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_cg,
   input  logic       i_uart_rx,
   output logic       o_uart_tx,
   output logic [7:0] o_bp_data,
   output logic       o_bp_valid,
   input  logic       i_bp_ready,
   input  logic [7:0] i_bp_data,
   input  logic       i_bp_valid,
   output logic       o_bp_ready,
   output logic       o_rxOverflow,
   output logic       o_rxFrameError
);
   localparam int             CW         = bit_cnt_width(CLKS_PER_BIT);
   localparam int             FW         = UART_FRAME_BITS - 1;
   localparam logic [CW-1:0]  C_HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]  C_FULL_BIT = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]     C_LAST_BIT = 3'(UART_DATA_W - 1);

   logic                   r_rx_s1, r_rx_s2, r_rx_s3;
   rx_state_t              r_rx_state;
   logic [CW-1:0]          r_rx_cnt;
   logic [2:0]             r_rx_bit;
   logic [UART_DATA_W-1:0] r_rx_shift;
   logic                   r_rx_ovf;
   logic                   r_rx_fe;
   tx_state_t              r_tx_state;
   logic [CW-1:0]          r_tx_cnt;
   logic [2:0]             r_tx_bit;
   logic [FW-1:0]          r_tx_frame;
   logic                   r_tx;
   logic                   w_rx_fall;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_empty;
   logic                   w_full;

   assign w_rx_fall      = r_rx_s3 & ~r_rx_s2;
   assign w_push         = (r_rx_state == RX_STOP) && (r_rx_cnt == '0) && r_rx_s2;
   assign w_pop          = o_bp_valid & i_bp_ready;
   assign o_bp_valid     = ~w_empty;
   assign o_rxOverflow   = r_rx_ovf;
   assign o_rxFrameError = r_rx_fe;
   assign o_uart_tx      = r_tx;
   assign o_bp_ready     = (r_tx_state == TX_IDLE);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
         r_rx_s3 <= 1'b1;
      end else if (i_cg) begin
         r_rx_s1 <= i_uart_rx;
         r_rx_s2 <= r_rx_s1;
         r_rx_s3 <= r_rx_s2;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_state <= RX_IDLE;
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
         r_rx_ovf   <= 1'b0;
         r_rx_fe    <= 1'b0;
      end else if (i_cg) begin
         r_rx_fe <= 1'b0;
         if (w_push && w_full && !i_bp_ready)
            r_rx_ovf <= 1'b1;
         case (r_rx_state)
            RX_IDLE: if (w_rx_fall) begin
               r_rx_cnt   <= C_HALF_BIT;
               r_rx_state <= RX_START;
            end
            RX_START: if (r_rx_cnt == '0) begin
               r_rx_cnt   <= C_FULL_BIT;
               r_rx_bit   <= '0;
               r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
            end else r_rx_cnt <= r_rx_cnt - CW'(1);
            RX_DATA: if (r_rx_cnt == '0) begin
               r_rx_shift <= {r_rx_s2, r_rx_shift[UART_DATA_W-1:1]};
               r_rx_cnt   <= C_FULL_BIT;
               if (r_rx_bit == C_LAST_BIT) r_rx_state <= RX_STOP;
               else                        r_rx_bit   <= r_rx_bit + 3'd1;
            end else r_rx_cnt <= r_rx_cnt - CW'(1);
            RX_STOP: if (r_rx_cnt == '0) begin
               r_rx_fe    <= ~r_rx_s2;
               r_rx_state <= r_rx_s2 ? RX_IDLE : RX_BREAK;
            end else r_rx_cnt <= r_rx_cnt - CW'(1);
            RX_BREAK: if (r_rx_s2) r_rx_state <= RX_IDLE;
            default: r_rx_state <= RX_IDLE;
         endcase
      end
   end

   bp_uart_rxfifo #(
      .DEPTH (RXFIFO_DEPTH),
      .WIDTH (UART_DATA_W)
   ) u_rxfifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_cg    (i_cg),
      .i_push  (w_push),
      .i_data  (r_rx_shift),
      .i_pop   (w_pop),
      .o_data  (o_bp_data),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   // The frame register holds data plus stop bit; ones shift in behind it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tx_state <= TX_IDLE;
         r_tx_cnt   <= '0;
         r_tx_bit   <= '0;
         r_tx_frame <= '1;
         r_tx       <= 1'b1;
      end else if (i_cg) begin
         case (r_tx_state)
            TX_IDLE: if (i_bp_valid) begin
               r_tx_frame <= {1'b1, i_bp_data};
               r_tx_cnt   <= C_FULL_BIT;
               r_tx       <= 1'b0;
               r_tx_state <= TX_START;
            end
            TX_START: if (r_tx_cnt == '0) begin
               r_tx       <= r_tx_frame[0];
               r_tx_frame <= {1'b1, r_tx_frame[FW-1:1]};
               r_tx_cnt   <= C_FULL_BIT;
               r_tx_bit   <= '0;
               r_tx_state <= TX_DATA;
            end else r_tx_cnt <= r_tx_cnt - CW'(1);
            TX_DATA: if (r_tx_cnt == '0) begin
               r_tx       <= r_tx_frame[0];
               r_tx_frame <= {1'b1, r_tx_frame[FW-1:1]};
               r_tx_cnt   <= C_FULL_BIT;
               if (r_tx_bit == C_LAST_BIT) r_tx_state <= TX_STOP;
               else                        r_tx_bit   <= r_tx_bit + 3'd1;
            end else r_tx_cnt <= r_tx_cnt - CW'(1);
            TX_STOP: if (r_tx_cnt == '0) r_tx_state <= TX_IDLE;
                     else                r_tx_cnt   <= r_tx_cnt - CW'(1);
            default: r_tx_state <= TX_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bp_uart_bridge.sv
// ============================================================================
//  Module   : tb_bp_uart_bridge
//  Brief    : Scoreboard bench: directed UART scenarios plus randomized RX/TX traffic.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bp_uart_bridge;
   localparam int CPB   = 16;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cg = 1'b1;
   logic       uart_rx = 1'b1;
   logic       bp_ready = 1'b0;
   logic       bp_valid = 1'b0;
   logic [7:0] bp_data_in = 8'h00;
   logic       uart_tx, bp_valid_o, bp_ready_o, ovf, fe;
   logic [7:0] bp_data_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   byte unsigned rx_exp[$];
   byte unsigned tx_exp[$];
   int  tx_starts[$];
   int  fe_count = 0;
   bit  fe_prev = 1'b0;
   bit  fe_wide = 1'b0;
   bit  tx_busy = 1'b0;
   logic tx_prev = 1'b1;
   int  tx_cnt = 0;
   logic [9:0] tx_bits = '0;
   bit  rx_rand_done = 1'b0;

   bp_uart_bridge #(.CLKS_PER_BIT(CPB), .RXFIFO_DEPTH(DEPTH)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_cg           (cg),
      .i_uart_rx      (uart_rx),
      .o_uart_tx      (uart_tx),
      .o_bp_data      (bp_data_o),
      .o_bp_valid     (bp_valid_o),
      .i_bp_ready     (bp_ready),
      .i_bp_data      (bp_data_in),
      .i_bp_valid     (bp_valid),
      .o_bp_ready     (bp_ready_o),
      .o_rxOverflow   (ovf),
      .o_rxFrameError (fe)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // RX scoreboard: every accepted BytePipe byte must match the oldest expected byte.
   always @(negedge clk) begin
      if (!rst) begin
         if (bp_valid_o && bp_ready) begin
            if (rx_exp.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rx_unexpected_pop: got 0x%02h expected no byte", bp_data_o);
            end else
               check("rx_byte", 32'(bp_data_o), 32'(rx_exp.pop_front()));
         end
         if (fe) begin
            fe_count++;
            if (fe_prev) fe_wide = 1'b1;
         end
         fe_prev = fe;
      end
   end

   // TX line decoder: finds start edges and samples each bit at its centre.
   always @(negedge clk) begin
      if (rst) tx_busy = 1'b0;
      else if (!tx_busy) begin
         if (tx_prev === 1'b1 && uart_tx === 1'b0) begin
            tx_busy = 1'b1;
            tx_cnt  = 0;
            tx_starts.push_back(cyc);
         end
      end else begin
         tx_cnt++;
         if (tx_cnt % CPB == CPB / 2) begin
            tx_bits[tx_cnt / CPB] = uart_tx;
            if (tx_cnt / CPB == 9) begin
               tx_busy = 1'b0;
               check("tx_start_stop_bits", 32'({tx_bits[9], tx_bits[0]}), 32'h2);
               if (tx_exp.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL tx_unexpected_frame: got 0x%02h expected no frame", tx_bits[8:1]);
               end else
                  check("tx_byte", 32'(tx_bits[8:1]), 32'(tx_exp.pop_front()));
            end
         end
      end
      tx_prev = uart_tx;
   end

   task automatic send_rx(input logic [7:0] b, input logic stop, input bit expect_push);
      if (expect_push) rx_exp.push_back(b);
      uart_rx = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) tick();
      end
      uart_rx = stop;
      repeat (CPB) tick();
      uart_rx = 1'b1;
   endtask

   task automatic send_tx(input logic [7:0] b);
      int n = 0;
      bp_data_in = b;
      bp_valid   = 1'b1;
      tx_exp.push_back(b);
      @(negedge clk);
      while (!bp_ready_o && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("tx_handshake_timeout", 32'(n >= 5000), 32'h0);
      tick();
      bp_valid = 1'b0;
      check("tx_low_after_handshake", 32'(uart_tx), 32'h0);
   endtask

   task automatic wait_rx_drain(input string name);
      int n = 0;
      while ((rx_exp.size() != 0 || bp_valid_o) && n < 3000) begin
         tick();
         n++;
      end
      check(name, 32'(rx_exp.size()), 32'h0);
   endtask

   task automatic wait_tx_drain(input string name);
      int n = 0;
      while ((tx_exp.size() != 0 || tx_busy || !bp_ready_o) && n < 5000) begin
         tick();
         n++;
      end
      check(name, 32'(tx_exp.size()), 32'h0);
   endtask

   initial begin
      int t0;
      int lat;
      int fe0;
      int ns;

      // Reset and idle
      tick();
      check("reset_outputs", 32'({uart_tx, bp_valid_o, bp_ready_o, ovf, fe}), 32'b10100);
      repeat (4) tick();
      rst = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         check("idle_outputs", 32'({uart_tx, bp_valid_o, bp_ready_o}), 32'b101);
      end

      // Single RX frame, latency to o_bp_valid
      bp_ready = 1'b1;
      t0 = cyc;
      lat = -1;
      fork
         send_rx(8'hA5, 1'b1, 1'b1);
         begin
            int n = 0;
            while (!bp_valid_o && n < 400) begin
               tick();
               n++;
            end
            lat = cyc - t0;
         end
      join
      check("rx_valid_latency_in_range", 32'(lat >= 154 && lat <= 157), 32'h1);
      wait_rx_drain("rx_a5_drained");
      check("rx_a5_no_overflow", 32'(ovf), 32'h0);
      check("rx_a5_no_frame_error", 32'(fe_count), 32'h0);

      // Overflow: consumer stalled, five frames into a four-deep FIFO
      bp_ready = 1'b0;
      for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1, i <= DEPTH);
      repeat (20) tick();
      check("ovf_set", 32'(ovf), 32'h1);
      check("ovf_valid_held", 32'(bp_valid_o), 32'h1);
      check("ovf_head_data_held", 32'(bp_data_o), 32'(rx_exp[0]));
      bp_ready = 1'b1;
      wait_rx_drain("ovf_four_pops");
      check("ovf_sticky", 32'(ovf), 32'h1);

      // TX back-to-back frames and frame period
      ns = tx_starts.size();
      send_tx(8'h55);
      send_tx(8'hC3);
      wait_tx_drain("tx_b2b_drained");
      check("tx_two_frames_seen", 32'(tx_starts.size() - ns), 32'h2);
      if (tx_starts.size() >= ns + 2)
         check("tx_frame_period", 32'(tx_starts[ns+1] - tx_starts[ns]), 32'd161);

      // Reset mid-frame forces line high and clears sticky overflow
      send_tx(8'h00);
      repeat (40) tick();
      check("tx_mid_frame_low", 32'(uart_tx), 32'h0);
      rst = 1'b1;
      tick();
      check("tx_rst_line_high", 32'(uart_tx), 32'h1);
      check("rst_outputs", 32'({bp_valid_o, bp_ready_o, ovf, fe}), 32'b0100);
      tx_exp.delete();
      rst = 1'b0;
      repeat (10) tick();

      // Framing error, then recovery
      fe0 = fe_count;
      send_rx(8'h3C, 1'b0, 1'b0);
      repeat (30) tick();
      check("fe_one_pulse", 32'(fe_count - fe0), 32'h1);
      check("fe_pulse_width", 32'(fe_wide), 32'h0);
      check("fe_nothing_pushed", 32'(bp_valid_o), 32'h0);
      send_rx(8'h7E, 1'b1, 1'b1);
      wait_rx_drain("fe_recovery_7e");

      // Glitch shorter than half a bit
      uart_rx = 1'b0;
      repeat (4) tick();
      uart_rx = 1'b1;
      repeat (60) tick();
      check("glitch_no_push", 32'(bp_valid_o), 32'h0);
      check("glitch_no_frame_error", 32'(fe_count - fe0), 32'h1);

      // Randomized concurrent RX and TX traffic
      fork
         begin
            for (int i = 0; i < 12; i++) begin
               repeat ($urandom_range(0, 20)) tick();
               send_rx(8'($urandom), 1'b1, 1'b1);
            end
            rx_rand_done = 1'b1;
         end
         begin
            for (int i = 0; i < 8; i++) begin
               repeat ($urandom_range(0, 30)) tick();
               send_tx(8'($urandom));
            end
         end
         begin
            while (!rx_rand_done) begin
               bp_ready = 1'($urandom_range(0, 1));
               tick();
            end
            bp_ready = 1'b1;
         end
      join
      wait_rx_drain("rand_rx_drained");
      wait_tx_drain("rand_tx_drained");
      check("rand_no_overflow", 32'(ovf), 32'h0);
      check("rand_no_frame_error", 32'(fe_count - fe0), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
